eth_tx_gmii_serializer: RTL

- Downstream stage of the transmit arbiter.
- Consumes the arbitrated 32-bit word stream, one frame at a time, over a valid/ready handshake.
- Drives GMII transmit byte-serially: 7-byte preamble, SFD, payload bytes, then an enforced inter-frame gap.
- FCS is not generated here; the upstream word stream already carries it.

---
 rtl/eth_tx_gmii_serializer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/eth_tx_gmii_serializer.sv
// Serializes a framed 32-bit word stream onto GMII: preamble, SFD, payload, then an enforced IFG.
// Outputs are registered; in_rdy is combinational. Mid-frame starvation emits one error byte and drains.
module eth_tx_gmii_serializer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [31:0] in_dat,
  input  logic [1:0]  in_be,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic        underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_ERR, S_DRAIN, S_IFG
  } state_t;

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
  localparam logic [5:0] IFG_LAST = 6'(IFG_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  be_q, be_d;
  logic        eof_q, eof_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [5:0]  ifg_cnt_q, ifg_cnt_d;
  logic [7:0]  txd_d;
  logic        tx_en_d, tx_er_d;
  logic        last_byte;

  assign last_byte = (idx_q == 2'd3) || (eof_q && (idx_q == be_q));
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    be_d      = be_q;
    eof_d     = eof_q;
    pre_cnt_d = pre_cnt_q;
    ifg_cnt_d = ifg_cnt_q;
    in_rdy    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_vld && in_sof) begin
          state_d   = S_PREAMBLE;
          pre_cnt_d = 4'd0;
        end else begin
          in_rdy = in_vld;
        end
      end
      S_PREAMBLE: begin
        if (pre_cnt_q == PRE_LAST) state_d = S_SFD;
        else                       pre_cnt_d = pre_cnt_q + 4'd1;
      end
      S_SFD: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          word_d  = in_dat;
          be_d    = in_be;
          eof_d   = in_eof;
          idx_d   = 2'd0;
          state_d = S_DATA;
        end else begin
          state_d = S_ERR;
        end
      end
      S_DATA: begin
        if (!last_byte) begin
          idx_d = idx_q + 2'd1;
        end else if (eof_q) begin
          state_d   = S_IFG;
          ifg_cnt_d = 6'd0;
        end else begin
          // Next word must be ready on this last byte to keep the byte stream gapless.
          in_rdy = 1'b1;
          if (in_vld) begin
            word_d = in_dat;
            be_d   = in_be;
            eof_d  = in_eof;
            idx_d  = 2'd0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ERR: state_d = S_DRAIN;
      S_DRAIN: begin
        if (in_vld && in_sof) begin
          state_d   = S_IFG;
          ifg_cnt_d = 6'd0;
        end else begin
          in_rdy = 1'b1;
          if (in_vld && in_eof) begin
            state_d   = S_IFG;
            ifg_cnt_d = 6'd0;
          end
        end
      end
      S_IFG: begin
        if (ifg_cnt_q == IFG_LAST) begin
          if (in_vld && in_sof) begin
            state_d   = S_PREAMBLE;
            pre_cnt_d = 4'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ifg_cnt_d = ifg_cnt_q + 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Wire contents for the next cycle are a decode of the next state.
    tx_en_d = (state_d == S_PREAMBLE) || (state_d == S_SFD) ||
              (state_d == S_DATA) || (state_d == S_ERR);
    tx_er_d = (state_d == S_ERR);
    case (state_d)
      S_PREAMBLE: txd_d = 8'h55;
      S_SFD:      txd_d = 8'hD5;
      S_DATA:     txd_d = word_d[{idx_d, 3'b000} +: 8];
      default:    txd_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_q     <= 32'd0;
      idx_q      <= 2'd0;
      be_q       <= 2'd0;
      eof_q      <= 1'b0;
      pre_cnt_q  <= 4'd0;
      ifg_cnt_q  <= 6'd0;
      gmii_txd   <= 8'd0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      be_q       <= be_d;
      eof_q      <= eof_d;
      pre_cnt_q  <= pre_cnt_d;
      ifg_cnt_q  <= ifg_cnt_d;
      gmii_txd   <= txd_d;
      gmii_tx_en <= tx_en_d;
      gmii_tx_er <= tx_er_d;
      underrun   <= tx_er_d;
    end
  end

endmodule
